// File: rtl/fmul_mant_seq_if.sv
// Handshake bundle between the FP32 multiplier front end and the normaliser:
// operand side (in_*, a, b) and result side (out_*, sign, reg_c, expc2).
interface fmul_mant_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic        sign;
   logic [47:0] reg_c;
   logic [8:0]  expc2;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sign, reg_c, expc2
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sign, reg_c, expc2
   );
endinterface

// File: rtl/fmul_mant_seq.sv
// FP32 multiplier front end: unpack, sign/exponent sum, iterative 24x24 shift-add mantissa product.
// Optional macro FMUL_MANT_ZERO_BYPASS_EN: zero/denormal operands skip the iterative pass.

// One partial-product lane: the shifted multiplicand, gated by one multiplier bit.
module fmul_mant_pp #(
   parameter int W  = 48,
   parameter int SH = 0
) (
   input  logic [W-1:0] i_a,
   input  logic         i_bit,
   output logic [W-1:0] o_pp
);
   assign o_pp = i_bit ? (i_a << SH) : '0;
endmodule

module fmul_mant_seq #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   fmul_mant_seq_if.slave  s_if
);
   localparam int BPC  = BITS_PER_CYCLE;
   localparam int ITER = 24 / BPC;
   localparam int CW   = 5;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [47:0]       r_a_sh;
   logic [23:0]       r_b_sh;
   logic [47:0]       r_acc;
   logic              r_sign;
   logic [8:0]        r_expc2;
   logic              r_out_valid;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_step;
   logic              w_flush;
   logic              w_last;
   logic [23:0]       w_ma;
   logic [23:0]       w_mb;
   logic [BPC-1:0][47:0] w_pp;
   logic [47:0]       w_step_sum;

   // Unpack: hidden bit set only for a nonzero exponent field.
   assign w_flush = (s_if.a[30:23] == 8'd0) || (s_if.b[30:23] == 8'd0);
   assign w_ma    = {(s_if.a[30:23] != 8'd0), s_if.a[22:0]};
   assign w_mb    = {(s_if.b[30:23] != 8'd0), s_if.b[22:0]};
   assign w_last  = (r_cnt == CW'(ITER - 1));

   // r_a_sh tracks A << (cnt*BPC); r_b_sh exposes the next BPC multiplier bits at its LSBs.
   for (genvar j = 0; j < BPC; j++) begin : g_pp
      fmul_mant_pp #(.W(48), .SH(j)) u_pp (
         .i_a  (r_a_sh),
         .i_bit(r_b_sh[j]),
         .o_pp (w_pp[j])
      );
   end

   always_comb begin
      w_step_sum = '0;
      for (int j = 0; j < BPC; j++) w_step_sum = w_step_sum + w_pp[j];
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (s_if.in_valid) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (s_if.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      w_in_ready = 1'b0;
      w_accept   = 1'b0;
      w_step     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = rst_n;
            w_accept   = s_if.in_valid;
         end
         S_BUSY:  w_step = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_acc   <= '0;
         r_sign  <= 1'b0;
         r_expc2 <= '0;
      end else if (w_accept) begin
         r_sign  <= s_if.a[31] ^ s_if.b[31];
         r_expc2 <= w_flush ? 9'd0 : ({1'b0, s_if.a[30:23]} + {1'b0, s_if.b[30:23]});
         r_a_sh  <= w_flush ? 48'd0 : {24'd0, w_ma};
         r_b_sh  <= w_flush ? 24'd0 : w_mb;
         r_acc   <= '0;
`ifdef FMUL_MANT_ZERO_BYPASS_EN
         // A flushed op only takes the final BUSY edge, so out_valid follows one edge later.
         r_cnt   <= w_flush ? CW'(ITER - 1) : '0;
`else
         r_cnt   <= '0;
`endif
      end else if (w_step) begin
         r_acc   <= r_acc + w_step_sum;
         r_a_sh  <= r_a_sh << BPC;
         r_b_sh  <= r_b_sh >> BPC;
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   assign s_if.in_ready  = w_in_ready;
   assign s_if.out_valid = r_out_valid;
   assign s_if.sign      = r_sign;
   assign s_if.reg_c     = r_acc;
   assign s_if.expc2     = r_expc2;
endmodule

// File: tb/tb_fmul_mant_seq.sv
// Scoreboard bench for fmul_mant_seq: BITS_PER_CYCLE=1 main instance plus a BITS_PER_CYCLE=4 instance.
module tb_fmul_mant_seq;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct {
      logic        sign;
      logic [47:0] c;
      logic [8:0]  e;
   } exp_t;

   exp_t sb[$];

   fmul_mant_seq_if bus ();
   fmul_mant_seq_if bus4 ();

   fmul_mant_seq #(.BITS_PER_CYCLE(1)) dut (.clk(clk), .rst_n(rst_n), .s_if(bus.slave));
   fmul_mant_seq #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .s_if(bus4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        r;
      logic [47:0] ma;
      logic [47:0] mb;
      r.sign = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
         r.c = 48'd0;
         r.e = 9'd0;
      end else begin
         ma  = {24'd0, 1'b1, a[22:0]};
         mb  = {24'd0, 1'b1, b[22:0]};
         r.c = ma * mb;
         r.e = {1'b0, a[30:23]} + {1'b0, b[30:23]};
      end
      return r;
   endfunction

   function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input int iter);
`ifdef FMUL_MANT_ZERO_BYPASS_EN
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 1;
`endif
      return iter;
   endfunction

   // Full transaction on the BPC=1 instance; leaves the result unconsumed if hold is set.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string nm, input bit hold);
      exp_t ex;
      int   n;
      int   w;
      int   lat;
      lat = lat_of(a, b, 24);
      sb.push_back(model(a, b));
      @(negedge clk);
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready got %b want 1", nm, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != lat) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", nm, n, lat);
      end
      ex = sb.pop_front();
      checks++;
      if (bus.sign !== ex.sign || bus.reg_c !== ex.c || bus.expc2 !== ex.e) begin
         errors++;
         $display("FAIL %s result got s=%b c=%h e=%0d want s=%b c=%h e=%0d",
                  nm, bus.sign, bus.reg_c, bus.expc2, ex.sign, ex.c, ex.e);
      end
      if (!hold) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.out_ready = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake got ov=%b ir=%b want ov=0 ir=1", nm, bus.out_valid, bus.in_ready);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.reg_c !== 48'd0 ||
          bus.expc2 !== 9'd0 || bus.sign !== 1'b0) begin
         errors++;
         $display("FAIL reset got ov=%b ir=%b c=%h e=%0d s=%b want all 0",
                  bus.out_valid, bus.in_ready, bus.reg_c, bus.expc2, bus.sign);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release in_ready got %b/%b want 1/1", bus.in_ready, bus4.in_ready);
      end
   endtask

   task automatic test_directed();
      run_op(32'h3F800000, 32'h3F800000, "one_x_one", 1'b0);
      run_op(32'h3FC00000, 32'h3FC00000, "1p5_sq", 1'b0);
      run_op(32'hC0000000, 32'h40400000, "neg2_x_3", 1'b0);
      run_op(32'h7F800000, 32'hFF800000, "inf_x_ninf", 1'b0);
   endtask

   task automatic test_flush();
      run_op(32'h00000000, 32'h43000000, "zero_x_128", 1'b0);
      run_op(32'hC3000000, 32'h00400000, "denorm_sign", 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         if (i == 4) a[30:23] = 8'd0;
         run_op(a, b, $sformatf("rand%0d", i), 1'b0);
      end
   endtask

   task automatic test_backpressure();
      exp_t ex;
      ex = model(32'h40A00000, 32'hBFC00000);
      run_op(32'h40A00000, 32'hBFC00000, "bp_first", 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a = 32'h3F800000 + 32'(i);
         bus.b = 32'h40000000;
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.reg_c !== ex.c ||
             bus.expc2 !== ex.e || bus.sign !== ex.sign) begin
            errors++;
            $display("FAIL bp_hold%0d got ov=%b ir=%b c=%h e=%0d want ov=1 ir=0 c=%h e=%0d",
                     i, bus.out_valid, bus.in_ready, bus.reg_c, bus.expc2, ex.c, ex.e);
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
      end
      run_op(32'h41200000, 32'h3E800000, "bp_next", 1'b0);
   endtask

   task automatic test_back_to_back();
      run_op(32'h3F8CCCCD, 32'h3FF33333, "b2b0", 1'b0);
      run_op(32'hBF7FFFFF, 32'hBF7FFFFF, "b2b1", 1'b0);
   endtask

   task automatic test_reset_midop();
      int seen;
      sb.push_back(model(32'h3FC00000, 32'h3FC00000));
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'h3FC00000;
      bus.b = 32'h3FC00000;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.reg_c !== 48'd0 || bus.expc2 !== 9'd0) begin
         errors++;
         $display("FAIL midreset got ov=%b c=%h e=%0d want 0/0/0", bus.out_valid, bus.reg_c, bus.expc2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready got %b want 1", bus.in_ready);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midreset_stale out_valid cycles got %0d want 0", seen);
      end
   endtask

   task automatic test_bpc4();
      exp_t ex;
      int   n;
      ex = model(32'hC0000000, 32'h40400000);
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.a = 32'hC0000000;
      bus4.b = 32'h40400000;
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      n = 0;
      while (bus4.out_valid !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL bpc4 latency got %0d want 6", n);
      end
      checks++;
      if (bus4.sign !== ex.sign || bus4.reg_c !== ex.c || bus4.expc2 !== ex.e) begin
         errors++;
         $display("FAIL bpc4 result got s=%b c=%h e=%0d want s=%b c=%h e=%0d",
                  bus4.sign, bus4.reg_c, bus4.expc2, ex.sign, ex.c, ex.e);
      end
      @(negedge clk);
      bus4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus4.out_ready = 1'b0;
      checks++;
      if (bus4.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bpc4 handshake out_valid got %b want 0", bus4.out_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b0;
      bus4.in_valid = 1'b0;
      bus4.a = '0;
      bus4.b = '0;
      bus4.out_ready = 1'b0;
      test_reset();
      test_directed();
      test_flush();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_bpc4();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
